alu_seq_calc: RTL and testbench

//  Sequential, parametrised calculator core for the board top level.

---
 rtl/alu_seq_calc_if.sv | 32 +++
 rtl/alu_seq_calc.sv | 201 ++++++++++++++++++++
 tb/tb_alu_seq_calc.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_calc_if.sv
// ---------------------------------------------------------------------------
// | alu_seq_calc_if : operand entry bus and registered result/status bundle |
// | Rev 1.0 - initial release                                               |
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_seq_calc_if #(
  parameter int M = 8
);
  logic [M-1:0] data_in;
  logic         load;
  logic [M-1:0] a_q;
  logic [M-1:0] b_q;
  logic [2:0]   op_q;
  logic [M-1:0] result;
  logic [3:0]   status;
  logic [2:0]   state_q;
  logic         busy;
  logic         done;

  modport master (
    output data_in, load,
    input  a_q, b_q, op_q, result, status, state_q, busy, done
  );

  modport slave (
    input  data_in, load,
    output a_q, b_q, op_q, result, status, state_q, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/alu_seq_calc.sv
// ---------------------------------------------------------------------------
// | alu_seq_calc : sequential calculator core, operands/opcode entered on   |
// | one bus. Optional shift-add multiply enabled by macro ALU_MUL_EN.       |
// | Rev 1.0 - initial release                                               |
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq_calc #(
  parameter int M = 8
) (
  input wire           clk,
  input wire           reset,
  alu_seq_calc_if.slave bus
);

  localparam int SW = $clog2(M);

  localparam logic [2:0] c_op_add = 3'd0;
  localparam logic [2:0] c_op_sub = 3'd1;
  localparam logic [2:0] c_op_or  = 3'd2;
  localparam logic [2:0] c_op_and = 3'd3;
  localparam logic [2:0] c_op_xor = 3'd4;
  localparam logic [2:0] c_op_shl = 3'd5;
  localparam logic [2:0] c_op_shr = 3'd6;
  localparam logic [2:0] c_op_mul = 3'd7;

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic         w_ld_a;
  logic         w_ld_b;
  logic         w_ld_op;
  logic         w_exec_last;
  logic         w_exec_done;

  logic [M-1:0] r_a;
  logic [M-1:0] r_b;
  logic [2:0]   r_op;
  logic [M-1:0] r_result;
  logic [3:0]   r_status;
  logic         r_done;

  logic [M:0]   w_sum;
  logic [M-1:0] w_diff;
  logic [M-1:0] w_res;
  logic         w_c;
  logic         w_v;

`ifdef ALU_MUL_EN
  localparam logic [SW-1:0] c_cnt_last = SW'(M - 1);

  logic [2*M-1:0] r_acc;
  logic [2*M-1:0] r_mcand;
  logic [M-1:0]   r_mplier;
  logic [SW-1:0]  r_cnt;
  logic [2*M-1:0] w_acc_next;

  assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_exec_last = (r_op != c_op_mul) || (r_cnt == c_cnt_last);

  // Accumulator is cleared as the opcode lands, so EXEC starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_ld_op) begin
      r_acc    <= '0;
      r_mcand  <= {{M{1'b0}}, r_a};
      r_mplier <= r_b;
      r_cnt    <= '0;
    end else if (r_state == S_EXEC) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SW'(1);
    end
  end
`else
  assign w_exec_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ld_a       = 1'b0;
    w_ld_b       = 1'b0;
    w_ld_op      = 1'b0;
    w_exec_done  = 1'b0;
    case (r_state)
      S_WAIT_A: if (bus.load) begin
        w_ld_a       = 1'b1;
        w_state_next = S_WAIT_B;
      end
      S_WAIT_B: if (bus.load) begin
        w_ld_b       = 1'b1;
        w_state_next = S_WAIT_OP;
      end
      S_WAIT_OP: if (bus.load) begin
        w_ld_op      = 1'b1;
        w_state_next = S_EXEC;
      end
      S_EXEC: if (w_exec_last) begin
        w_exec_done  = 1'b1;
        w_state_next = S_SHOW;
      end
      S_SHOW: if (bus.load) begin
        w_ld_a       = 1'b1;
        w_state_next = S_WAIT_B;
      end
      default: w_state_next = S_WAIT_A;
    endcase
  end

  always_comb begin
    w_sum  = {1'b0, r_a} + {1'b0, r_b};
    w_diff = r_a - r_b;
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (r_op)
      c_op_add: begin
        w_res = w_sum[M-1:0];
        w_c   = w_sum[M];
        w_v   = (r_a[M-1] == r_b[M-1]) && (w_sum[M-1] != r_a[M-1]);
      end
      c_op_sub: begin
        w_res = w_diff;
        w_c   = (r_a >= r_b);
        w_v   = (r_a[M-1] != r_b[M-1]) && (w_diff[M-1] != r_a[M-1]);
      end
      c_op_or:  w_res = r_a | r_b;
      c_op_and: w_res = r_a & r_b;
      c_op_xor: w_res = r_a ^ r_b;
      c_op_shl: w_res = r_a << r_b[SW-1:0];
      c_op_shr: w_res = r_a >> r_b[SW-1:0];
      c_op_mul: begin
`ifdef ALU_MUL_EN
        w_res = w_acc_next[M-1:0];
        w_c   = |w_acc_next[2*M-1:M];
`else
        w_res = '0;
`endif
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_status <= 4'b0000;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_exec_done;
      if (w_ld_a) begin
        r_a <= bus.data_in;
      end
      if (w_ld_b) begin
        r_b <= bus.data_in;
      end
      if (w_ld_op) begin
        r_op <= bus.data_in[2:0];
      end
      if (w_exec_done) begin
        r_result <= w_res;
        r_status <= {w_res[M-1], (w_res == '0), w_c, w_v};
      end
    end
  end

  assign bus.a_q     = r_a;
  assign bus.b_q     = r_b;
  assign bus.op_q    = r_op;
  assign bus.result  = r_result;
  assign bus.status  = r_status;
  assign bus.state_q = r_state;
  assign bus.busy    = (r_state == S_EXEC);
  assign bus.done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_calc.sv
// ---------------------------------------------------------------------------
// | tb_alu_seq_calc : directed bench with result/status scoreboard          |
// | Rev 1.0 - initial release                                               |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq_calc;
  localparam int M = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_calc_if #(.M(M)) bus ();
  alu_seq_calc #(.M(M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [M-1:0] res;
    logic [3:0]   st;
    int           busy;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [M-1:0] last_res;
  logic [3:0]   last_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [M-1:0] v);
    bus.data_in = v;
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
    bus.data_in = '0;
  endtask

  // Independent reference: wide integer arithmetic and signed range tests.
  function automatic exp_t model(input logic [M-1:0] a, input logic [M-1:0] b, input logic [2:0] op);
    exp_t           e;
    int             sa, sb, full, smax;
    logic [M-1:0]   r;
    logic [2*M-1:0] p;
    logic           c, v;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    smax = (1 << (M - 1)) - 1;
    c = 1'b0; v = 1'b0; r = '0; e.busy = 1;
    case (op)
      3'd0: begin
        full = int'(a) + int'(b);
        r = full[M-1:0];
        c = (full > ((1 << M) - 1));
        v = ((sa + sb) > smax) || ((sa + sb) < -smax - 1);
      end
      3'd1: begin
        full = int'(a) - int'(b);
        r = full[M-1:0];
        c = (int'(a) >= int'(b));
        v = ((sa - sb) > smax) || ((sa - sb) < -smax - 1);
      end
      3'd2: r = a | b;
      3'd3: r = a & b;
      3'd4: r = a ^ b;
      3'd5: r = a << (int'(b) % M);
      3'd6: r = a >> (int'(b) % M);
      default: begin
`ifdef ALU_MUL_EN
        p = (2*M)'(a) * (2*M)'(b);
        r = p[M-1:0];
        c = (p[2*M-1:M] != '0);
        e.busy = M;
`else
        p = '0;
        r = p[M-1:0];
`endif
      end
    endcase
    e.res = r;
    e.st  = {r[M-1], (r == '0), c, v};
    return e;
  endfunction

  task automatic wait_done(output int busy_cycles, output int steps, output bit seen);
    busy_cycles = 0; steps = 0; seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) busy_cycles++;
        step();
        steps++;
      end
    end
  endtask

  // Loads the opcode (A/B already in), then pops and compares on done.
  task automatic finish_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [2:0] op,
                           input bit use_exp, input logic [M-1:0] xres, input logic [3:0] xst);
    exp_t e;
    int   bc, st;
    bit   seen;
    e = model(a, b, op);
    if (use_exp) begin
      e.res = xres;
      e.st  = xst;
    end
    sb_q.push_back(e);
    load_val({{(M-3){1'b0}}, op});
    chk("busy_in_exec", bus.busy, 1);
    wait_done(bc, st, seen);
    chk("done_seen", seen, 1);
    e = sb_q.pop_front();
    chk("result", bus.result, e.res);
    chk("status", bus.status, e.st);
    chk("busy_cycles", bc, e.busy);
    chk("done_latency", st, e.busy);
    chk("state_show", bus.state_q, 4);
    last_res = e.res;
    last_st  = e.st;
    step();
    chk("done_pulse_end", bus.done, 0);
    chk("result_hold", bus.result, e.res);
  endtask

  task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [2:0] op,
                        input bit use_exp, input logic [M-1:0] xres, input logic [3:0] xst);
    load_val(a);
    load_val(b);
    chk("a_q", bus.a_q, a);
    chk("b_q", bus.b_q, b);
    finish_op(a, b, op, use_exp, xres, xst);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, bus.state_q, 0);
    chk({tag, "_a"}, bus.a_q, 0);
    chk({tag, "_b"}, bus.b_q, 0);
    chk({tag, "_op"}, bus.op_q, 0);
    chk({tag, "_res"}, bus.result, 0);
    chk({tag, "_st"}, bus.status, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a simultaneous load, which must be discarded.
    reset = 1'b1; bus.load = 1'b1; bus.data_in = 8'h55;
    step();
    step();
    reset = 1'b0; bus.load = 1'b0; bus.data_in = '0;
    chk_zero("reset");
    step();
    chk("idle_state", bus.state_q, 0);

    run_op(8'h7F, 8'h01, 3'd0, 1, 8'h80, 4'b1001);
    run_op(8'h05, 8'h05, 3'd1, 1, 8'h00, 4'b0110);
    run_op(8'h03, 8'h05, 3'd1, 1, 8'hFE, 4'b1000);
    run_op(8'h80, 8'h0B, 3'd6, 1, 8'h10, 4'b0000);
    run_op(8'h81, 8'h01, 3'd5, 1, 8'h02, 4'b0000);
`ifdef ALU_MUL_EN
    run_op(8'h10, 8'h11, 3'd7, 1, 8'h10, 4'b0010);
`else
    run_op(8'h10, 8'h11, 3'd7, 1, 8'h00, 4'b0100);
`endif
    run_op(8'hA5, 8'h3C, 3'd4, 0, '0, '0);
    run_op(8'hF0, 8'h0F, 3'd2, 0, '0, '0);
    run_op(8'hF0, 8'h3C, 3'd3, 0, '0, '0);
    run_op(8'hFF, 8'h01, 3'd0, 0, '0, '0);
    run_op(8'h80, 8'h01, 3'd1, 0, '0, '0);
    run_op(8'h01, 8'h0F, 3'd5, 0, '0, '0);
    run_op(8'hFF, 8'hFF, 3'd7, 0, '0, '0);

    // Fast re-entry from SHOW: A reloads, result holds until next EXEC ends.
    load_val(8'h22);
    chk("reentry_a", bus.a_q, 8'h22);
    chk("reentry_state", bus.state_q, 1);
    chk("reentry_res", bus.result, last_res);
    load_val(8'h03);
    chk("reentry_res2", bus.result, last_res);
    chk("reentry_st2", bus.status, last_st);
    finish_op(8'h22, 8'h03, 3'd0, 0, '0, '0);

    // Load pulse during a single-cycle EXEC must be ignored.
    load_val(8'h10);
    load_val(8'h11);
    sb_q.push_back(model(8'h10, 8'h11, 3'd0));
    load_val(8'h00);
    bus.load = 1'b1; bus.data_in = 8'hAA;
    step();
    bus.load = 1'b0; bus.data_in = '0;
    begin
      exp_t e;
      e = sb_q.pop_front();
      chk("exec_ld_state", bus.state_q, 4);
      chk("exec_ld_a", bus.a_q, 8'h10);
      chk("exec_ld_b", bus.b_q, 8'h11);
      chk("exec_ld_op", bus.op_q, 0);
      chk("exec_ld_res", bus.result, e.res);
    end
    step();

    // Reset during EXEC aborts everything.
    load_val(8'h10);
    load_val(8'h11);
    load_val(8'h07);
`ifdef ALU_MUL_EN
    bus.load = 1'b1; bus.data_in = 8'hAA;
    step();
    bus.load = 1'b0; bus.data_in = '0;
    chk("mul_ld_a", bus.a_q, 8'h10);
    chk("mul_ld_b", bus.b_q, 8'h11);
    chk("mul_ld_op", bus.op_q, 7);
    step();
    step();
    chk("mul_c4_busy", bus.busy, 1);
    chk("mul_c4_state", bus.state_q, 3);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("abort");
    step();
    chk("abort_no_done", bus.done, 0);
    chk("abort_state", bus.state_q, 0);

    run_op(8'h12, 8'h34, 3'd0, 0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
